data_mem_access_unit: RTL and testbench
=======================================

// Module: data_mem_access_unit
// PURPOSE
//  Memory-stage responder to the MemRead/MemWrite controls from the control unit. Converts one
//  LOAD/STORE per instruction into a req/ack transaction on a 32-bit word bus, with byte-lane
//  enables and load sign/zero extension. Asserts stall until the access completes.
// PARAMETERS
//  TIMEOUT_CYC  16  cycles in REQ without bus_ack before the access is aborted (>=2)
//  CNT_W        5   width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYC
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  MemRead    in   1   load request from control unit (LOAD opcode)
//  MemWrite   in   1   store request from control unit (STORE opcode)
//  funct3     in   3   000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 are handled as W
//  addr       in   32  byte address (ALU result)
//  wdata      in   32  store data (rs2)
//  rdata      out  32  extended load data; valid in the DONE cycle and held until the next load completes
//  stall      out  1   combinational: (MemRead|MemWrite) && state!=DONE
//  mem_err    out  1   one-cycle pulse in DONE on timeout (or on misalignment, see CONFIGURATION)
//  bus_req    out  1   registered request; held high until bus_ack
//  bus_we     out  1   1 = write
//  bus_addr   out  32  {addr[31:2],2'b00}
//  bus_be     out  4   byte enables
//  bus_wdata  out  32  lane-replicated store data
//  bus_ack    in   1   one-cycle completion from memory
//  bus_rdata  in   32  read word; valid with bus_ack
// BEHAVIOUR
//  Reset: state=IDLE. bus_req, bus_we, mem_err = 0. bus_addr, bus_be, bus_wdata, rdata = 0.
//  FSM states: IDLE -> REQ -> DONE -> IDLE.
//   IDLE: on MemRead|MemWrite, latch bus fields, set bus_req=1, go to REQ. MemWrite wins if both are set.
//   REQ: bus_* held stable. On bus_ack: capture extended load data and go to DONE.
//        Counter increments each cycle without ack; at TIMEOUT_CYC, drop bus_req, set rdata=0,
//        mem_err=1, go to DONE.
//   DONE: stall=0 for exactly one cycle so the pipeline advances; bus_req=0; go to IDLE.
//        Requests are not sampled in DONE.
//  Latency: request in cycle 0, bus_req high in cycle 1, ack in cycle 1 gives DONE in cycle 2.
//   Minimum is 2 stall cycles.
//  Back-to-back memory instructions: the second one is sampled in the IDLE cycle after DONE.
//  bus_ack while in IDLE or DONE is ignored. An ack in the same cycle as timeout completes normally.
//  Stores: SB: be=1<<addr[1:0], wdata={4{wdata[7:0]}}. SH: be=addr[1]?1100:0011,
//   wdata={2{wdata[15:0]}}. SW: be=1111.
//  Loads: lane chosen by addr[1:0] (B) or addr[1] (H). B/H sign-extend; BU/HU zero-extend.
//   bus_be=1111 on reads.
//  Reset mid-transaction: bus_req drops asynchronously; any late ack is ignored.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: H with addr[0]=1, or W with addr[1:0]!=0, issues no bus request.
//   Goes IDLE->DONE directly with mem_err=1, rdata unchanged, memory unmodified.
//  Not defined: misaligned low bits are ignored (H uses addr[1], W uses the whole word); no error.
// STRUCTURE
//  Shared package riscv_pkg: funct3 load/store encodings and the state encoding (IDLE/REQ/DONE).
//  Sub-module load_extend: combinational lane select plus sign/zero extension
//   (bus_rdata, addr[1:0], funct3 -> 32b).
// TESTING
//  1 LW addr=0x100, ack in the first REQ cycle, bus_rdata=0xDEADBEEF -> stall for 2 cycles,
//    rdata=0xDEADBEEF in DONE.
//  2 LB addr=0x103, bus_rdata=0x80FF0000 -> rdata=0xFFFFFF80. LBU at the same address -> rdata=0x00000080.
//  3 SH addr=0x202, wdata=0x1234ABCD -> bus_be=1100, bus_wdata=0xABCDABCD, bus_addr=0x200, bus_we=1.
//  4 LW with no ack, TIMEOUT_CYC=16 -> bus_req high for 16 cycles, then mem_err pulse and rdata=0.
//  5 Two consecutive LWs with ack delayed by 3 cycles -> each completes once, no duplicate bus_req,
//    stall drops once per instruction.
//  6 rst_n low while in REQ -> bus_req=0 immediately; later ack ignored; next LW is normal.
//    With MISALIGN_TRAP_EN, LW addr=0x101 -> no bus_req, mem_err pulse.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the memory stage: funct3 load/store sizes, FSM states,
// the latched bus payload and the store lane/alignment helpers.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } bus_fields_t;

  // Reads always fetch the whole word; writes enable only the addressed lanes.
  function automatic logic [BE_W-1:0] store_be(input logic we, input logic [2:0] f3,
                                               input logic [1:0] lo);
    logic [BE_W-1:0] be;
    be = '1;
    if (we) begin
      case (f3)
        F3_B, F3_BU: be = BE_W'(1) << lo;
        F3_H, F3_HU: be = lo[1] ? 4'b1100 : 4'b0011;
        default:     be = '1;
      endcase
    end
    return be;
  endfunction

  function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] f3,
                                                  input logic [XLEN-1:0] wd);
    logic [XLEN-1:0] d;
    case (f3)
      F3_B, F3_BU: d = {4{wd[7:0]}};
      F3_H, F3_HU: d = {2{wd[15:0]}};
      default:     d = wd;
    endcase
    return d;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic m;
    case (f3)
      F3_B, F3_BU: m = 1'b0;
      F3_H, F3_HU: m = lo[0];
      default:     m = (lo != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_mem_access_unit_if.sv
// Word bus between the memory-stage access unit (master) and data memory (slave).
interface data_mem_access_unit_if;
  import riscv_pkg::*;

  logic            bus_req;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [BE_W-1:0] bus_be;
  logic [XLEN-1:0] bus_wdata;
  logic            bus_ack;
  logic [XLEN-1:0] bus_rdata;

  modport master (output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
                  input  bus_ack, bus_rdata);
  modport slave  (input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
                  output bus_ack, bus_rdata);
endinterface

// File: rtl/data_mem_access_unit_load_extend.sv
// Load lane select and sign/zero extension of a bus read word.
module load_extend
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      lane_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] load_data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (lane_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

    case (funct3_i)
      F3_B:    load_data_c = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data_c = {24'h0, byte_sel};
      F3_H:    load_data_c = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data_c = {16'h0, half_sel};
      default: load_data_c = word_i;
    endcase
  end

endmodule

// File: rtl/data_mem_access_unit.sv
// Memory-stage LOAD/STORE responder: one req/ack word-bus transaction per instruction,
// stalling the pipeline until DONE. Define MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module data_mem_access_unit
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  input  logic [XLEN-1:0]       addr,
  input  logic [XLEN-1:0]       wdata,
  output logic [XLEN-1:0]       rdata,
  output logic                  stall,
  output logic                  mem_err,
  data_mem_access_unit_if.master bus
);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  bus_fields_t     fld_q, fld_d;
  logic            req_q, req_d;
  logic [1:0]      lane_q, lane_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] load_c;
  logic            trap_c;
  logic            mem_op_c;

  load_extend u_load_extend (
    .word_i      (bus.bus_rdata),
    .lane_i      (lane_q),
    .funct3_i    (f3_q),
    .load_data_c (load_c)
  );

  assign mem_op_c = MemRead | MemWrite;

  always_comb begin
`ifdef MISALIGN_TRAP_EN
    trap_c = misaligned(funct3, addr[1:0]);
`else
    trap_c = 1'b0;
`endif
  end

  // Next-state: IDLE latches the access, REQ waits for ack or timeout, DONE releases the stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fld_d   = fld_q;
    req_d   = req_q;
    lane_d  = lane_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_op_c) begin
          if (trap_c) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            fld_d.we    = MemWrite;
            fld_d.addr  = {addr[XLEN-1:2], 2'b00};
            fld_d.be    = store_be(MemWrite, funct3, addr[1:0]);
            fld_d.wdata = store_wdata(funct3, wdata);
            lane_d      = addr[1:0];
            f3_d        = funct3;
            cnt_d       = '0;
            req_d       = 1'b1;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (bus.bus_ack) begin
          if (!fld_q.we) rdata_d = load_c;
          req_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fld_q   <= '0;
      req_q   <= 1'b0;
      lane_q  <= 2'b00;
      f3_q    <= F3_W;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fld_q   <= fld_d;
      req_q   <= req_d;
      lane_q  <= lane_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign stall         = mem_op_c && (state_q != ST_DONE);
  assign rdata         = rdata_q;
  assign mem_err       = err_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = fld_q.we;
  assign bus.bus_addr  = fld_q.addr;
  assign bus.bus_be    = fld_q.be;
  assign bus.bus_wdata = fld_q.wdata;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Scoreboard bench for data_mem_access_unit: byte-level reference memory, randomized
// loads/stores with a reactive bus slave, and a monitor checking bus fields and DONE responses.
module tb_data_mem_access_unit;
  import riscv_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int NOACK   = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  funct3 = 3'b010;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        stall;
  logic        mem_err;

  data_mem_access_unit_if bus_if();

  data_mem_access_unit #(.TIMEOUT_CYC(TIMEOUT), .CNT_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .mem_err  (mem_err),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stall_cyc;
  } resp_exp_t;

  bus_exp_t    bus_q[$];
  resp_exp_t   resp_q[$];
  int          delay_q[$];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] smem    [logic [31:0]];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return 8'((a ^ (a >> 8)) * 37 + 11);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [31:0] slave_word(input logic [31:0] wa);
    return smem.exists(wa) ? smem[wa]
         : {init_byte(wa + 3), init_byte(wa + 2), init_byte(wa + 1), init_byte(wa)};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] wa;
    logic [31:0] r;
    b  = ref_byte(a);
    h  = {ref_byte((a & ~32'h1) + 1), ref_byte(a & ~32'h1)};
    wa = a & ~32'h3;
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0, h};
      default: r = {ref_byte(wa + 3), ref_byte(wa + 2), ref_byte(wa + 1), ref_byte(wa)};
    endcase
    return r;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    case (f3)
      3'b000: ref_mem[a] = wd[7:0];
      3'b001: begin
        ref_mem[a & ~32'h1]       = wd[7:0];
        ref_mem[(a & ~32'h1) + 1] = wd[15:8];
      end
      default: for (int i = 0; i < 4; i++) ref_mem[(a & ~32'h3) + i] = wd[8*i +: 8];
    endcase
  endtask

`ifdef MISALIGN_TRAP_EN
  function automatic logic ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
    if (f3 == 3'b001 || f3 == 3'b101) return a[0];
    return a[1:0] != 2'b00;
  endfunction
`endif

  // Issue one memory instruction, push its expectations, hold it until the DONE cycle.
  task automatic do_txn(input logic wr, input logic both, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int d);
    bus_exp_t  e;
    resp_exp_t r;
    logic      trap;
    int        waited;
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = ref_misaligned(f3, a);
`endif
    if (trap) begin
      r.rdata = last_rdata; r.err = 1'b1; r.stall_cyc = 1;
    end else begin
      e.we    = wr;
      e.addr  = a & ~32'h3;
      e.be    = 4'b1111;
      e.wdata = wd;
      if (wr && f3 == 3'b000) begin e.be = 4'b0001 << a[1:0]; e.wdata = {4{wd[7:0]}}; end
      if (wr && f3 == 3'b001) begin e.be = a[1] ? 4'b1100 : 4'b0011; e.wdata = {2{wd[15:0]}}; end
      bus_q.push_back(e);
      delay_q.push_back(d);
      if (d >= TIMEOUT) begin
        last_rdata = 32'h0;
        r.rdata = 32'h0; r.err = 1'b1; r.stall_cyc = TIMEOUT + 1;
      end else begin
        if (wr) ref_store(f3, a, wd);
        else    last_rdata = ref_load(f3, a);
        r.rdata = last_rdata; r.err = 1'b0; r.stall_cyc = d + 2;
      end
    end
    resp_q.push_back(r);
    @(posedge clk); #1;
    MemWrite = wr; MemRead = !wr || both; funct3 = f3; addr = a; wdata = wd;
    waited = 0;
    do begin @(negedge clk); waited++; end while (stall && waited < 100);
    if (stall) begin
      n_cmp++; n_bad++;
      $display("FAIL txn_complete: stall still high after %0d cycles, required low", waited);
      summary();
      $finish;
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Monitor: bus fields at each new request, response checks in each DONE cycle.
  initial begin : monitor
    bit        prev_req;
    int        stall_cnt;
    bus_exp_t  cur;
    bus_exp_t  e;
    resp_exp_t r;
    prev_req  = 1'b0;
    stall_cnt = 0;
    cur       = '{1'b0, 32'h0, 4'h0, 32'h0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req  = 1'b0;
        stall_cnt = 0;
      end else begin
        if (bus_if.bus_req && !prev_req) begin
          if (bus_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL bus_req: got unexpected request addr 0x%08h, required none", bus_if.bus_addr);
          end else begin
            e = bus_q.pop_front();
            cur = e;
            check("bus_we", 32'(bus_if.bus_we), 32'(e.we));
            check("bus_addr", bus_if.bus_addr, e.addr);
            check("bus_be", 32'(bus_if.bus_be), 32'(e.be));
            if (e.we) check("bus_wdata", bus_if.bus_wdata, e.wdata);
          end
        end else if (bus_if.bus_req) begin
          check("bus_addr_stable", bus_if.bus_addr, cur.addr);
        end
        prev_req = bus_if.bus_req;
        if (MemRead || MemWrite) begin
          if (stall) stall_cnt++;
          else if (resp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done: got unexpected completion, required none");
          end else begin
            r = resp_q.pop_front();
            check("rdata", rdata, r.rdata);
            check("mem_err", 32'(mem_err), 32'(r.err));
            check("stall_cycles", 32'(stall_cnt), 32'(r.stall_cyc));
            stall_cnt = 0;
          end
        end else if (mem_err) begin
          check("mem_err_idle", 32'(mem_err), 32'h0);
        end
      end
    end
  end

  // Bus slave: acks after the delay queued for each request; NOACK lets the access time out.
  initial begin : slave
    int          d;
    int          guard;
    logic [31:0] w;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0;
    forever begin
      @(posedge clk); #2;
      if (bus_if.bus_req && rst_n) begin
        if (delay_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL slave_req: got request with no queued delay, required none");
          d = NOACK;
        end else d = delay_q.pop_front();
        if (d == NOACK) begin
          guard = 0;
          while (bus_if.bus_req && guard < 200) begin @(posedge clk); #2; guard++; end
        end else begin
          repeat (d) begin @(posedge clk); #2; end
          w = slave_word(bus_if.bus_addr);
          bus_if.bus_rdata = w;
          if (bus_if.bus_req && bus_if.bus_we) begin
            for (int i = 0; i < 4; i++)
              if (bus_if.bus_be[i]) w[8*i +: 8] = bus_if.bus_wdata[8*i +: 8];
            smem[bus_if.bus_addr] = w;
          end
          bus_if.bus_ack = 1'b1;
          @(posedge clk); #2;
          bus_if.bus_ack   = 1'b0;
          bus_if.bus_rdata = $urandom;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    summary();
    $fatal(1);
  end

  initial begin : main
    logic        wr;
    logic [2:0]  f3;
    int          r;
    int          d;
    logic [2:0]  ld_f3 [8];
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

    #12;
    check("reset_bus_req", 32'(bus_if.bus_req), 32'h0);
    check("reset_bus_we", 32'(bus_if.bus_we), 32'h0);
    check("reset_bus_addr", bus_if.bus_addr, 32'h0);
    check("reset_bus_be", 32'(bus_if.bus_be), 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_mem_err", 32'(mem_err), 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(2);

    do_txn(1'b1, 1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 0);
    do_txn(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 0);
    idle(1);
    do_txn(1'b1, 1'b0, 3'b010, 32'h100, 32'h80FF0000, 1);
    do_txn(1'b0, 1'b0, 3'b000, 32'h103, 32'h0, 0);
    do_txn(1'b0, 1'b0, 3'b100, 32'h103, 32'h0, 2);
    do_txn(1'b1, 1'b0, 3'b001, 32'h202, 32'h1234ABCD, 0);
    do_txn(1'b0, 1'b0, 3'b001, 32'h200, 32'h0, 0);
    do_txn(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, NOACK);
    do_txn(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 3);
    do_txn(1'b0, 1'b0, 3'b010, 32'h104, 32'h0, 3);
    do_txn(1'b0, 1'b0, 3'b010, 32'h108, 32'h0, TIMEOUT - 1);
    do_txn(1'b1, 1'b1, 3'b000, 32'h10D, 32'h000000A5, 1);
    do_txn(1'b0, 1'b0, 3'b100, 32'h10D, 32'h0, 0);

    // Reset while the request is outstanding; the slave's late ack must be ignored.
    @(posedge clk); #1;
    MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; addr = 32'h104;
    bus_q.push_back('{1'b0, 32'h104, 4'b1111, 32'h0});
    delay_q.push_back(5);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0; MemRead = 1'b0;
    #1;
    check("async_reset_bus_req", 32'(bus_if.bus_req), 32'h0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    last_rdata = 32'h0;
    idle(10);
    check("post_reset_rdata", rdata, 32'h0);
    check("post_reset_bus_req", 32'(bus_if.bus_req), 32'h0);
    do_txn(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 0);

`ifdef MISALIGN_TRAP_EN
    do_txn(1'b0, 1'b0, 3'b010, 32'h101, 32'h0, 0);
    do_txn(1'b1, 1'b0, 3'b001, 32'h103, 32'h55667788, 0);
`endif

    for (int i = 0; i < 300; i++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = wr ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 7)];
      r  = $urandom_range(0, 19);
      if (r < 12)       d = r % 4;
      else if (r < 16)  d = r - 8;
      else if (r < 18)  d = TIMEOUT - 1;
      else if (r == 18) d = NOACK;
      else              d = TIMEOUT - 2;
      do_txn(wr, 1'($urandom_range(0, 1)), f3, 32'h100 + 32'($urandom_range(0, 63)), $urandom, d);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 2));
    end

    idle(5);
    check("queues_drained", 32'(bus_q.size() + resp_q.size() + delay_q.size()), 32'h0);
    summary();
    $finish;
  end

endmodule
